// File: rtl/tx_gate_pkg.sv
// Shared definitions for the transmit-side gated unpacker: FSM state
// encoding, frame sizing constants and the channel-count decode helper.
package tx_gate_pkg;

  // Unpacker control states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_READY = 2'd2
  } tx_state_e;

  // One 512-byte USB packet expressed in 16-bit words
  localparam int DEF_PACKET_WORDS = 256;

  // Largest frame: I0,Q0,I1,Q1
  localparam int MAX_WORDS = 4;

  // Words per frame for a requested channel count; only 2 selects two
  // channels, every other encoding falls back to a single channel.
  function automatic logic [2:0] frame_words(input logic [1:0] numchan);
    return (numchan == 2'd2) ? 3'd4 : 3'd2;
  endfunction

endpackage

// File: rtl/tx_sample_fifo.sv
// Synchronous word FIFO with first-word fall-through read data, a level
// count and full/empty flags. Pointers carry one extra wrap bit so the
// level is a plain subtraction and full/empty need no extra state.
module tx_sample_fifo #(
  parameter int AW = 9
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [15:0]   wr_data,
  input  logic          rd_en,
  output logic [15:0]   rd_data,
  output logic [AW:0]   level,
  output logic          full,
  output logic          empty
);

  localparam int DEPTH = 2 ** AW;

  logic [15:0] mem [DEPTH];
  logic [AW:0] wr_ptr_q;
  logic [AW:0] rd_ptr_q;
  logic        wr_ok;
  logic        rd_ok;

  assign level = wr_ptr_q - rd_ptr_q;
  assign full  = (level == (AW + 1)'(DEPTH));
  assign empty = (level == '0);

  // A write on full is dropped; a read on empty is ignored.
  assign wr_ok = wr_en && !full;
  assign rd_ok = rd_en && !empty;

  assign rd_data = mem[rd_ptr_q[AW-1:0]];

  // Storage array: data only, no reset needed
  always_ff @(posedge clock) begin
    if (wr_ok) begin
      mem[wr_ptr_q[AW-1:0]] <= wr_data;
    end
  end

  // Read and write pointers, wrapping modulo 2*DEPTH via the extra bit
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (rd_ok) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/tx_gated_unpacker.sv
// Transmit-side gated unpacker. Buffers USB words, assembles them into
// per-channel I/Q frames and releases one frame per gated interpolator
// strobe. Frames are only staged once fully present in the FIFO, so
// frame alignment survives any amount of gating.
module tx_gated_unpacker
  import tx_gate_pkg::*;
#(
  parameter int AW           = 9,
  parameter int PACKET_WORDS = DEF_PACKET_WORDS
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [15:0]        wr_data,
  output logic               have_space,
  output logic [AW:0]        fifo_level,
  input  logic [1:0]         tx_numchan,
  input  logic               interp_strobe,
  input  logic               gate_enable,
  input  logic               clear_status,
  output logic               tx_strobe,
  output logic signed [15:0] i_out0,
  output logic signed [15:0] q_out0,
  output logic signed [15:0] i_out1,
  output logic signed [15:0] q_out1,
  output logic               wr_overrun,
  output logic               tx_underrun
);

  logic        fifo_rd;
  logic [15:0] fifo_rd_data;
  logic        fifo_full;
  logic        fifo_empty;

  tx_state_e   state_q;
  logic [2:0]  frame_words_q;
  logic [1:0]  word_cnt_q;
  logic [2:0]  frame_words_in;
  logic        frame_present;
  logic        last_pop;
  logic        fire;

  logic signed [15:0] stage_p0 [MAX_WORDS];

  logic signed [15:0] i0_p1;
  logic signed [15:0] q0_p1;
  logic signed [15:0] i1_p1;
  logic signed [15:0] q1_p1;
  logic               vld_p1;

  tx_sample_fifo #(
    .AW (AW)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (fifo_rd),
    .rd_data (fifo_rd_data),
    .level   (fifo_level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign have_space = (((AW + 1)'(2 ** AW) - fifo_level) >= (AW + 1)'(PACKET_WORDS));

  assign frame_words_in = frame_words(tx_numchan);
  assign frame_present  = (fifo_level >= (AW + 1)'(frame_words_in));
  assign fire           = interp_strobe && gate_enable;

  // Pops stall while the gate is low; the empty guard never trips in
  // practice because LOAD starts only with a whole frame buffered.
  assign fifo_rd  = (state_q == ST_LOAD) && gate_enable && !fifo_empty;
  assign last_pop = (word_cnt_q == 2'(frame_words_q - 3'd1));

  // Frame sequencing: wait for a full frame, load it, hold until released
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      frame_words_q <= 3'd2;
      word_cnt_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          frame_words_q <= frame_words_in;
          word_cnt_q    <= '0;
          if (frame_present) begin
            state_q <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (fifo_rd) begin
            word_cnt_q <= word_cnt_q + 2'd1;
            if (last_pop) begin
              state_q <= ST_READY;
            end
          end
        end
        ST_READY: begin
          if (fire) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // ---- stage p0: staging registers filled in I0,Q0,I1,Q1 order ----
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < MAX_WORDS; k++) begin
        stage_p0[k] <= '0;
      end
    end else if (fifo_rd) begin
      stage_p0[word_cnt_q] <= $signed(fifo_rd_data);
    end
  end

  // ---- stage p1: output registers, gated to zero and strobe-released ----
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      i0_p1  <= '0;
      q0_p1  <= '0;
      i1_p1  <= '0;
      q1_p1  <= '0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= 1'b0;
      if (!gate_enable) begin
        i0_p1 <= '0;
        q0_p1 <= '0;
        i1_p1 <= '0;
        q1_p1 <= '0;
      end else if (interp_strobe) begin
        if (state_q == ST_READY) begin
          i0_p1  <= stage_p0[0];
          q0_p1  <= stage_p0[1];
          i1_p1  <= (frame_words_q == 3'(MAX_WORDS)) ? stage_p0[2] : '0;
          q1_p1  <= (frame_words_q == 3'(MAX_WORDS)) ? stage_p0[3] : '0;
          vld_p1 <= 1'b1;
        end else begin
          i0_p1 <= '0;
          q0_p1 <= '0;
          i1_p1 <= '0;
          q1_p1 <= '0;
        end
      end
    end
  end

  assign i_out0    = i0_p1;
  assign q_out0    = q0_p1;
  assign i_out1    = i1_p1;
  assign q_out1    = q1_p1;
  assign tx_strobe = vld_p1;

  // Sticky status: a new event in the clearing cycle wins over the clear
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_overrun  <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      if (wr_en && fifo_full) begin
        wr_overrun <= 1'b1;
      end else if (clear_status) begin
        wr_overrun <= 1'b0;
      end
      if (fire && (state_q != ST_READY)) begin
        tx_underrun <= 1'b1;
      end else if (clear_status) begin
        tx_underrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tx_gated_unpacker.sv
// Directed bench for tx_gated_unpacker with a frame-queue reference model
// and a per-cycle compare process.
module tb_tx_gated_unpacker;

  localparam int AW    = 9;
  localparam int DEPTH = 2 ** AW;
  localparam int PKT   = 256;

  logic               clock = 1'b0;
  logic               reset = 1'b0;
  logic               wr_en = 1'b0;
  logic [15:0]        wr_data = '0;
  logic               have_space;
  logic [AW:0]        fifo_level;
  logic [1:0]         tx_numchan = 2'd1;
  logic               interp_strobe = 1'b0;
  logic               gate_enable = 1'b0;
  logic               clear_status = 1'b0;
  logic               tx_strobe;
  logic signed [15:0] i_out0, q_out0, i_out1, q_out1;
  logic               wr_overrun, tx_underrun;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: every accepted word not yet emitted, in order
  logic [15:0] model_q [$];
  int          cur_n = 1;
  logic        chk_en = 1'b0;
  logic        g_s = 1'b0;
  logic        sg_s = 1'b0;
  logic [15:0] exp_w [4];

  tx_gated_unpacker #(.AW(AW), .PACKET_WORDS(PKT)) dut (
    .clock         (clock),
    .reset         (reset),
    .wr_en         (wr_en),
    .wr_data       (wr_data),
    .have_space    (have_space),
    .fifo_level    (fifo_level),
    .tx_numchan    (tx_numchan),
    .interp_strobe (interp_strobe),
    .gate_enable   (gate_enable),
    .clear_status  (clear_status),
    .tx_strobe     (tx_strobe),
    .i_out0        (i_out0),
    .q_out0        (q_out0),
    .i_out1        (i_out1),
    .q_out1        (q_out1),
    .wr_overrun    (wr_overrun),
    .tx_underrun   (tx_underrun)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // Inputs seen by the DUT at each active edge
  always @(posedge clock) begin
    g_s  <= gate_enable;
    sg_s <= gate_enable && interp_strobe;
  end

  // Per-cycle compare against the frame model
  always @(negedge clock) begin
    if (chk_en && reset) begin
      n_checks++;
      if (have_space !== ((DEPTH - int'(fifo_level)) >= PKT)) begin
        n_errors++;
        $display("FAIL have_space: got %0b with level %0d", have_space, fifo_level);
      end
      if (!g_s || (sg_s && !tx_strobe)) begin
        n_checks++;
        if (tx_strobe !== 1'b0 || i_out0 !== 16'sd0 || q_out0 !== 16'sd0 ||
            i_out1 !== 16'sd0 || q_out1 !== 16'sd0) begin
          n_errors++;
          $display("FAIL zero_outputs: got strobe=%0b %h %h %h %h required all 0",
                   tx_strobe, i_out0, q_out0, i_out1, q_out1);
        end
      end
      if (tx_strobe === 1'b1) begin
        n_checks++;
        if (!sg_s) begin
          n_errors++;
          $display("FAIL spurious_strobe: tx_strobe=1 without gated strobe");
        end else if (model_q.size() < 2 * cur_n) begin
          n_errors++;
          $display("FAIL model_frame: tx_strobe=1 but model holds %0d words", model_q.size());
        end else begin
          for (int k = 0; k < 4; k++) exp_w[k] = 16'h0000;
          for (int k = 0; k < 2 * cur_n; k++) exp_w[k] = model_q.pop_front();
          if (16'(i_out0) !== exp_w[0] || 16'(q_out0) !== exp_w[1] ||
              16'(i_out1) !== exp_w[2] || 16'(q_out1) !== exp_w[3]) begin
            n_errors++;
            $display("FAIL frame: got %h %h %h %h required %h %h %h %h",
                     i_out0, q_out0, i_out1, q_out1,
                     exp_w[0], exp_w[1], exp_w[2], exp_w[3]);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wr1(input logic [15:0] w, input bit push);
    wr_en   = 1'b1;
    wr_data = w;
    tick();
    wr_en   = 1'b0;
    if (push) model_q.push_back(w);
  endtask

  task automatic strobe_pulse(input bit clr);
    interp_strobe = 1'b1;
    clear_status  = clr;
    tick();
    interp_strobe = 1'b0;
    clear_status  = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_q.delete();
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic chk_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0b required %0b", name, act, exp);
    end
  endtask

  task automatic chk_lvl(input string name, input int exp);
    n_checks++;
    if (int'(fifo_level) != exp) begin
      n_errors++;
      $display("FAIL %s: level %0d required %0d", name, fifo_level, exp);
    end
  endtask

  task automatic chk_frame(input string name, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] c, input logic [15:0] d);
    n_checks++;
    if (16'(i_out0) !== a || 16'(q_out0) !== b || 16'(i_out1) !== c || 16'(q_out1) !== d) begin
      n_errors++;
      $display("FAIL %s: got %h %h %h %h required %h %h %h %h",
               name, i_out0, q_out0, i_out1, q_out1, a, b, c, d);
    end
  endtask

  task automatic wait_tx(input string name, input int max);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < max && !seen; i++) begin
      @(negedge clock);
      if (tx_strobe === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (!seen) begin
      n_errors++;
      $display("FAIL %s: no tx_strobe within %0d cycles", name, max);
    end
  endtask

  initial begin
    // Reset state
    tx_numchan  = 2'd1;
    cur_n       = 1;
    gate_enable = 1'b1;
    tick();
    tick();
    chk_frame("reset_outputs", 16'h0, 16'h0, 16'h0, 16'h0);
    chk_bit("reset_tx_strobe", tx_strobe, 1'b0);
    chk_bit("reset_have_space", have_space, 1'b1);
    chk_lvl("reset_level", 0);
    chk_bit("reset_overrun", wr_overrun, 1'b0);
    chk_bit("reset_underrun", tx_underrun, 1'b0);
    reset  = 1'b1;
    tick();
    chk_en = 1'b1;

    // 1: single channel frame
    wr1(16'h1111, 1);
    wr1(16'h2222, 1);
    repeat (6) tick();
    strobe_pulse(0);
    wait_tx("t1_strobe", 4);
    chk_frame("t1_frame", 16'h1111, 16'h2222, 16'h0000, 16'h0000);
    tick();
    repeat (4) tick();
    chk_lvl("t1_level", 0);
    chk_bit("t1_underrun", tx_underrun, 1'b0);

    // 2: two channels, two frames
    tx_numchan = 2'd2;
    cur_n      = 2;
    for (int k = 0; k < 8; k++) wr1(16'hA000 + 16'(k), 1);
    repeat (4) tick();
    strobe_pulse(0);
    wait_tx("t2_strobe_a", 4);
    chk_frame("t2_frame_a", 16'hA000, 16'hA001, 16'hA002, 16'hA003);
    tick();
    repeat (8) tick();
    strobe_pulse(0);
    wait_tx("t2_strobe_b", 4);
    chk_frame("t2_frame_b", 16'hA004, 16'hA005, 16'hA006, 16'hA007);
    tick();
    repeat (4) tick();
    chk_lvl("t2_level", 0);

    // 3: gate low holds everything
    gate_enable = 1'b0;
    for (int k = 0; k < 4; k++) wr1(16'hB000 + 16'(k), 1);
    for (int s = 0; s < 5; s++) begin
      strobe_pulse(0);
      repeat (7) tick();
    end
    chk_lvl("t3_level_held", 4);
    chk_bit("t3_no_underrun", tx_underrun, 1'b0);
    chk_frame("t3_outputs_zero", 16'h0, 16'h0, 16'h0, 16'h0);
    gate_enable = 1'b1;
    repeat (10) tick();
    strobe_pulse(0);
    wait_tx("t3_strobe", 4);
    chk_frame("t3_frame", 16'hB000, 16'hB001, 16'hB002, 16'hB003);
    tick();
    repeat (4) tick();

    // 4: underrun and sticky clear
    strobe_pulse(0);
    @(negedge clock);
    chk_bit("t4_underrun_set", tx_underrun, 1'b1);
    chk_frame("t4_outputs_zero", 16'h0, 16'h0, 16'h0, 16'h0);
    tick();
    clear_status = 1'b1;
    tick();
    clear_status = 1'b0;
    chk_bit("t4_underrun_cleared", tx_underrun, 1'b0);
    strobe_pulse(1);
    chk_bit("t4_clear_vs_event", tx_underrun, 1'b1);
    clear_status = 1'b1;
    tick();
    clear_status = 1'b0;
    chk_bit("t4_final_clear", tx_underrun, 1'b0);

    // 5: fill, overrun, have_space thresholds, drain
    gate_enable = 1'b0;
    do_reset();
    for (int k = 0; k < PKT; k++) wr1(16'(k), 1);
    chk_lvl("t5_level_256", 256);
    chk_bit("t5_space_at_256", have_space, 1'b1);
    wr1(16'(PKT), 1);
    chk_lvl("t5_level_257", 257);
    chk_bit("t5_space_at_257", have_space, 1'b0);
    for (int k = PKT + 1; k < DEPTH; k++) wr1(16'(k), 1);
    chk_lvl("t5_level_full", DEPTH);
    chk_bit("t5_no_overrun_yet", wr_overrun, 1'b0);
    wr1(16'hDEAD, 0);
    chk_bit("t5_overrun", wr_overrun, 1'b1);
    chk_lvl("t5_level_after_drop", DEPTH);
    clear_status = 1'b1;
    tick();
    clear_status = 1'b0;
    chk_bit("t5_overrun_cleared", wr_overrun, 1'b0);
    gate_enable = 1'b1;
    repeat (8) tick();
    for (int s = 0; s < 70; s++) begin
      strobe_pulse(0);
      repeat (7) tick();
    end
    chk_lvl("t5_level_drained", DEPTH - 71 * 4);
    chk_bit("t5_space_back", have_space, 1'b1);
    chk_bit("t5_drain_no_underrun", tx_underrun, 1'b0);

    // 6: reset in the middle of a load
    gate_enable = 1'b0;
    do_reset();
    for (int k = 0; k < 4; k++) wr1(16'hC000 + 16'(k), 1);
    repeat (4) tick();
    chk_lvl("t6_level_before", 4);
    gate_enable = 1'b1;
    tick();
    tick();
    gate_enable = 1'b0;
    @(negedge clock);
    chk_lvl("t6_two_popped", 2);
    reset = 1'b0;
    #1;
    model_q.delete();
    chk_lvl("t6_level_reset", 0);
    chk_frame("t6_outputs_reset", 16'h0, 16'h0, 16'h0, 16'h0);
    tick();
    reset       = 1'b1;
    gate_enable = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) wr1(16'hD000 + 16'(k), 1);
    repeat (8) tick();
    strobe_pulse(0);
    wait_tx("t6_strobe", 4);
    chk_frame("t6_frame", 16'hD000, 16'hD001, 16'hD002, 16'hD003);
    tick();
    repeat (4) tick();
    chk_lvl("t6_level_end", 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
